serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: computes diff = a - b and borrow-out, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/serial_subtractor_half_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants and helpers for the bit-serial subtractor.
// WIDTH is the only value shared outside the core.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit counter width; WIDTH >= 2 keeps this at least one bit.
  function automatic int unsigned count_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The slave modport is the subtractor; the master modport is its producer/consumer.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// Half subtractor cell: d = x - y (mod 2), b = borrow out.
// Two of these plus an OR make one full-subtract bit cell.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);

  assign d = x ^ y;
  assign b = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock,
// behind a valid/ready operand interface with a held valid/ready result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             borrow;
  logic [CW-1:0]    count;

  logic hs0_d, hs0_b, hs1_d, hs1_b;
  logic br_next;
  logic [WIDTH-1:0] res_next;

  half_subtractor u_hs0 (.x(a_sr[0]), .y(b_sr[0]), .d(hs0_d), .b(hs0_b));
  half_subtractor u_hs1 (.x(hs0_d),   .y(borrow),  .d(hs1_d), .b(hs1_b));

  assign br_next  = hs0_b | hs1_b;
  assign res_next = {hs1_d, res_sr[WIDTH-1:1]};

  // NOTE: shift registers are plain flops here, so they take the async reset
  // like everything else; nothing is left to power-up contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      borrow <= 1'b0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of the shift registers and borrow.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            borrow <= 1'b0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= br_next;
          if (count == LAST_BIT) begin
            // Counter parks at zero so it never exceeds WIDTH-1.
            count  <= '0;
            diff_q <= res_next;
            bout_q <= br_next;
            state  <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode registered state only; no input-to-output path.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vectors and corner sequences,
// plus an exhaustive WIDTH=2 instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(2)) bus2 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after an edge with dut8 idle; returns result and accept-to-valid cycles.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output logic [7:0] d, output logic bo, output int lat);
    bus8.a = av;
    bus8.b = bv;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = bus8.diff;
    bo = bus8.bout;
    @(posedge clk); #1;
  endtask

  task automatic run2(input logic [1:0] av, input logic [1:0] bv,
                      output logic [1:0] d, output logic bo, output int lat);
    bus2.a = av;
    bus2.b = bv;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    lat = 0;
    while (!bus2.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = bus2.diff;
    bo = bus2.bout;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] d;
    logic       bo;
    int         lat;
    logic [1:0] d2;
    logic       bo2;
    logic [7:0] b2b_a[4];
    logic [7:0] b2b_b[4];
    logic [7:0] b2b_d[4];

    vecs[0] = '{a: 8'd5,    b: 8'd3,    diff: 8'd2,    bout: 1'b0};
    vecs[1] = '{a: 8'd3,    b: 8'd5,    diff: 8'hFE,   bout: 1'b1};
    vecs[2] = '{a: 8'd0,    b: 8'd255,  diff: 8'd1,    bout: 1'b1};
    vecs[3] = '{a: 8'hA5,   b: 8'hA5,   diff: 8'd0,    bout: 1'b0};
    vecs[4] = '{a: 8'd255,  b: 8'd0,    diff: 8'd255,  bout: 1'b0};
    vecs[5] = '{a: 8'd128,  b: 8'd1,    diff: 8'd127,  bout: 1'b0};
    vecs[6] = '{a: 8'd0,    b: 8'd1,    diff: 8'hFF,   bout: 1'b1};
    vecs[7] = '{a: 8'h3C,   b: 8'hC3,   diff: 8'h79,   bout: 1'b1};

    b2b_a = '{8'd50, 8'd7,  8'd100, 8'd240};
    b2b_b = '{8'd20, 8'd9,  8'd100, 8'd15};
    b2b_d = '{8'd30, 8'hFE, 8'd0,   8'd225};

    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_diff_bout", {bus8.bout, bus8.diff}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, d, bo, lat);
      check($sformatf("vec%0d_diff", i), d, vecs[i].diff);
      check($sformatf("vec%0d_bout", i), bo, vecs[i].bout);
      check($sformatf("vec%0d_latency", i), lat, 8);
    end

    // Backpressure with ignored operand pulses during RUN and DONE
    bus8.out_ready = 1'b0;
    bus8.a = 8'd10; bus8.b = 8'd20; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_busy", bus8.busy, 1);
    check("bp_in_ready_run", bus8.in_ready, 0);
    bus8.a = 8'd1; bus8.b = 8'd1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_diff", bus8.diff, 8'hF6);
    check("bp_bout", bus8.bout, 1);
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", i),
            {bus8.out_valid, bus8.in_ready, bus8.busy, bus8.bout, bus8.diff},
            {1'b1, 1'b0, 1'b0, 1'b1, 8'hF6});
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {bus8.out_valid, bus8.in_ready}, 2'b01);
    check("bp_diff_held", {bus8.bout, bus8.diff}, {1'b1, 8'hF6});

    // Back-to-back: in_valid and out_ready held high
    begin
      int acc = 0;
      int res = 0;
      int last = -1;
      logic ir;
      bus8.a = b2b_a[0]; bus8.b = b2b_b[0]; bus8.in_valid = 1'b1;
      for (int cyc = 0; cyc < 80 && res < 4; cyc++) begin
        ir = bus8.in_ready;
        @(posedge clk); #1;
        if (ir) begin
          acc++;
          if (acc < 4) begin
            bus8.a = b2b_a[acc];
            bus8.b = b2b_b[acc];
          end else begin
            bus8.in_valid = 1'b0;
          end
        end
        if (bus8.out_valid) begin
          check($sformatf("b2b%0d_diff", res), bus8.diff, b2b_d[res]);
          if (last >= 0) check($sformatf("b2b%0d_period", res), cyc - last, 10);
          last = cyc;
          res++;
        end
      end
      bus8.in_valid = 1'b0;
      check("b2b_count", res, 4);
      @(posedge clk); #1;
    end

    // Reset in the middle of RUN at count=4
    bus8.a = 8'd77; bus8.b = 8'd11; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", bus8.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_flags", {bus8.in_ready, bus8.out_valid, bus8.busy}, 3'b100);
    check("mid_rst_outputs", {bus8.bout, bus8.diff}, 0);
    @(negedge clk); rst = 1'b0;
    begin
      logic saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (bus8.out_valid) saw_valid = 1'b1;
      end
      check("mid_no_result", saw_valid, 0);
    end
    run8(8'd200, 8'd100, d, bo, lat);
    check("post_rst_diff", d, 8'd100);
    check("post_rst_bout", bo, 0);

    // WIDTH=2 exhaustive
    for (int i = 0; i < 16; i++) begin
      logic [1:0] av;
      logic [1:0] bv;
      logic [2:0] ex;
      av = i[3:2];
      bv = i[1:0];
      ex = {(av < bv), 2'(av - bv)};
      run2(av, bv, d2, bo2, lat);
      check($sformatf("w2_%0d_%0d", av, bv), {bo2, d2}, ex);
    end
    check("w2_latency", lat, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
